rf_shutdown_sequencer: RTL and testbench
========================================

# rf_shutdown_sequencer

Downstream consumer of the watchdog timer's `warning`/`triggered` outputs in the AM radio FPGA datapath. Converts a watchdog trip or operator disable into a controlled carrier gain ramp-down, latches the fault, and holds the transmitter muted until an explicit clear. Drives the gain word applied to the AM modulator and the RF output enable.

## Interface
Parameters:
- `GAIN_W`, 16, width of gain words
- `STEP`, 256, gain increment/decrement per ramp tick, 1..2^GAIN_W-1
- `RAMP_DIV`, 1000, clock cycles per ramp tick, ≥1

Ports:
- `clk` in 1: system clock
- `rstn` in 1: reset, asynchronous, active-low
- `enable` in 1: operator transmit enable, level
- `wd_warning` in 1: watchdog pre-expiry warning, level
- `wd_triggered` in 1: watchdog expired, level
- `fault_clear` in 1: one-cycle software acknowledge
- `target_gain` in GAIN_W: requested carrier gain, unsigned
- `gain_out` out GAIN_W: gain applied to modulator, registered
- `rf_enable` out 1: RF output stage enable, registered
- `fault_latched` out 1: sticky watchdog fault flag
- `fault_clear_ack` out 1: one-cycle pulse when a clear is accepted
- `state_out` out 3: current FSM state encoding

## Operation
- States: MUTED, RAMP_UP, RUN, RAMP_DOWN, FAULT.
- MUTED: gain 0, rf_enable 0. `enable && !wd_triggered` → RAMP_UP; rf_enable goes 1 on entry.
- RAMP_UP: each tick gain = min(gain+STEP, target_gain); gain == target_gain → RUN. `wd_triggered` → RAMP_DOWN, set fault_latched. `!enable` → RAMP_DOWN.
- RUN: gain_out = target_gain every cycle. `wd_triggered` → RAMP_DOWN, set fault_latched; `!enable` → RAMP_DOWN.
- RAMP_DOWN: each tick gain = max(gain−STEP, 0), no wrap. gain == 0 → FAULT if fault_latched else MUTED; rf_enable 0 on that transition. `wd_triggered` while in RAMP_DOWN sets fault_latched.
- FAULT: gain 0, rf_enable 0. `fault_clear && !wd_triggered` → MUTED, clear fault_latched, pulse fault_clear_ack. Clear while `wd_triggered` ignored, no ack. `enable` ignored.
- Arithmetic in GAIN_W+1 bits, saturated back to GAIN_W.
- target_gain below current gain during RAMP_UP: gain clamps to target_gain immediately, → RUN.
- Simultaneous `wd_triggered` and `!enable`: fault path wins (fault_latched set).
- `fault_clear` outside FAULT: ignored.

## Timing
- Reset (async assert, sync-deasserted usage assumed by top): state MUTED, gain_out 0, rf_enable 0, fault_latched 0, fault_clear_ack 0, state_out MUTED encoding, tick counter 0.
- Inputs sampled on rising edge; state and outputs update at that edge (one-cycle latency).
- Tick counter restarts on every state entry; first step occurs RAMP_DIV cycles after entering RAMP_UP/RAMP_DOWN, then every RAMP_DIV cycles.
- Full ramp from G to 0: ceil(G/STEP)·RAMP_DIV cycles plus 1 transition cycle.
- fault_clear_ack high exactly one cycle, same edge as FAULT → MUTED.
- Reset mid-ramp: outputs zero immediately, no completion of ramp.

## Configuration
- `RF_SHUTDOWN_WARN_ATTEN_EN`: when defined, in RUN and RAMP_UP the effective target is target_gain>>1 while `wd_warning` is high (pre-emptive 6 dB attenuation, applied immediately); restored when warning drops. When undefined, `wd_warning` is ignored.

## Structure
- Shared package `rf_shutdown_pkg`: state enum (3-bit), state encodings for `state_out`, default GAIN_W.
- Sub-module `ramp_tick_gen`: RAMP_DIV-cycle counter with synchronous restart input, one-cycle `tick` output.

## Test plan
Use GAIN_W=8, STEP=16, RAMP_DIV=4.
- Reset, enable=1, target=64 → RAMP_UP; gain 16,32,48,64 on ticks at 4-cycle spacing, → RUN, rf_enable 1.
- In RUN gain 64, wd_triggered pulse → RAMP_DOWN, fault_latched 1; gain 48,32,16,0; → FAULT, rf_enable 0.
- In FAULT, fault_clear with wd_triggered=1 → no change; with wd_triggered=0 → MUTED, ack one cycle, fault_latched 0.
- In RUN, enable=0 → ramp to 0 → MUTED, fault_latched stays 0.
- target=250, STEP=16: final ramp-up step saturates at 250, no wrap; rstn asserted mid-ramp → all outputs 0 immediately.
- With `RF_SHUTDOWN_WARN_ATTEN_EN`, RUN target 64, wd_warning=1 → gain 32 next cycle; warning low → 64.

Source files
------------

// File: rtl/rf_shutdown_pkg.sv
// Purpose : shared types for the RF shutdown sequencer (state enum, default gain width).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package rf_shutdown_pkg;

    localparam int GAIN_W_DEFAULT = 16;

    // Encodings are also what the sequencer exposes on state_out.
    typedef enum logic [2:0] {
        ST_MUTED     = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Purpose : free-running RAMP_DIV-cycle divider that paces gain ramp steps.
// Latency : tick fires RAMP_DIV cycles after the last restart, then every RAMP_DIV cycles.
// Backpr. : none; restart is sampled every cycle and wins over counting.
//
// Ports: clk, rstn (async active-low), restart (sync, returns count to 0),
//        tick (one-cycle pulse, combinational from the registered count).
module ramp_tick_gen #(
    parameter int RAMP_DIV = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int               CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count value LAST is the RAMP_DIV-th cycle since restart.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rf_shutdown_sequencer.sv
// Purpose : turns a watchdog trip or operator disable into a paced carrier gain ramp-down,
//           latches watchdog faults and keeps RF muted until software acknowledges.
// Latency : one cycle from sampled inputs to registered gain/rf_enable/state outputs.
// Backpr. : none; level inputs are sampled every cycle, fault_clear is a one-cycle strobe.
//
// Ports: clk, rstn (async active-low); enable, wd_warning, wd_triggered (levels);
//        fault_clear (strobe); target_gain (requested gain); gain_out, rf_enable,
//        fault_latched, fault_clear_ack (one-cycle), state_out (rf_shutdown_pkg::state_e).
// Option: define RF_SHUTDOWN_WARN_ATTEN_EN to halve the effective target while wd_warning is high.
module rf_shutdown_sequencer
    import rf_shutdown_pkg::*;
#(
    parameter int GAIN_W   = GAIN_W_DEFAULT,
    parameter int STEP     = 256,
    parameter int RAMP_DIV = 1000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              wd_warning,
    input  logic              wd_triggered,
    input  logic              fault_clear,
    input  logic [GAIN_W-1:0] target_gain,
    output logic [GAIN_W-1:0] gain_out,
    output logic              rf_enable,
    output logic              fault_latched,
    output logic              fault_clear_ack,
    output logic [2:0]        state_out
);

    localparam logic [GAIN_W:0] STEP_W = (GAIN_W + 1)'(STEP);

    state_e            state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              rf_en_q, rf_en_d;
    logic              fault_q, fault_d;
    logic              ack_q, ack_d;

    logic              tick;
    logic              restart;
    logic [GAIN_W-1:0] eff_target;
    logic [GAIN_W:0]   sum_up;
    logic [GAIN_W:0]   diff_dn;
    logic [GAIN_W-1:0] gain_up;
    logic [GAIN_W-1:0] gain_dn;

`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
    // Pre-emptive 6 dB back-off while the watchdog is about to expire.
    assign eff_target = wd_warning ? (target_gain >> 1) : target_gain;
`else
    logic unused_wd_warning;
    assign unused_wd_warning = wd_warning;
    assign eff_target        = target_gain;
`endif

    // One extra bit so gain+STEP cannot wrap and gain-STEP exposes the borrow.
    assign sum_up  = {1'b0, gain_q} + STEP_W;
    assign diff_dn = {1'b0, gain_q} - STEP_W;
    assign gain_up = (sum_up > {1'b0, eff_target}) ? eff_target : sum_up[GAIN_W-1:0];
    assign gain_dn = diff_dn[GAIN_W] ? '0 : diff_dn[GAIN_W-1:0];

    // Every state entry restarts the step pacing.
    assign restart = (state_d != state_q);

    ramp_tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        rf_en_d = rf_en_q;
        fault_d = fault_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_MUTED: begin
                gain_d  = '0;
                rf_en_d = 1'b0;
                if (enable && !wd_triggered) begin
                    state_d = ST_RAMP_UP;
                    rf_en_d = 1'b1;
                end
            end

            ST_RAMP_UP: begin
                // Watchdog is checked first so a simultaneous disable still latches the fault.
                if (wd_triggered) begin
                    state_d = ST_RAMP_DOWN;
                    fault_d = 1'b1;
                end else if (!enable) begin
                    state_d = ST_RAMP_DOWN;
                end else if (gain_q >= eff_target) begin
                    // Covers both arrival and a target lowered below the current gain.
                    gain_d  = eff_target;
                    state_d = ST_RUN;
                end else if (tick) begin
                    gain_d = gain_up;
                end
            end

            ST_RUN: begin
                gain_d = eff_target;
                if (wd_triggered) begin
                    state_d = ST_RAMP_DOWN;
                    fault_d = 1'b1;
                end else if (!enable) begin
                    state_d = ST_RAMP_DOWN;
                end
            end

            ST_RAMP_DOWN: begin
                if (wd_triggered) begin
                    fault_d = 1'b1;
                end
                if (gain_q == '0) begin
                    state_d = fault_d ? ST_FAULT : ST_MUTED;
                    rf_en_d = 1'b0;
                end else if (tick) begin
                    gain_d = gain_dn;
                end
            end

            ST_FAULT: begin
                gain_d  = '0;
                rf_en_d = 1'b0;
                // A clear is only honoured once the watchdog has stopped asserting.
                if (fault_clear && !wd_triggered) begin
                    state_d = ST_MUTED;
                    fault_d = 1'b0;
                    ack_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_MUTED;
                gain_d  = '0;
                rf_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_MUTED;
            gain_q  <= '0;
            rf_en_q <= 1'b0;
            fault_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            rf_en_q <= rf_en_d;
            fault_q <= fault_d;
            ack_q   <= ack_d;
        end
    end

    assign gain_out        = gain_q;
    assign rf_enable       = rf_en_q;
    assign fault_latched   = fault_q;
    assign fault_clear_ack = ack_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_rf_shutdown_sequencer.sv
// Purpose : self-checking bench for rf_shutdown_sequencer (GAIN_W=8, STEP=16, RAMP_DIV=4).
// Latency : model advances on each rising edge; outputs compared on the falling edge.
// Backpr. : n/a.
module tb_rf_shutdown_sequencer;

    localparam int GW  = 8;
    localparam int STP = 16;
    localparam int DIV = 4;

    // State codes in the order the states are listed for the block.
    localparam int S_MUTED = 0;
    localparam int S_UP    = 1;
    localparam int S_RUN   = 2;
    localparam int S_DOWN  = 3;
    localparam int S_FAULT = 4;

    logic          clk;
    logic          rstn;
    logic          enable;
    logic          wd_warning;
    logic          wd_triggered;
    logic          fault_clear;
    logic [GW-1:0] target_gain;
    logic [GW-1:0] gain_out;
    logic          rf_enable;
    logic          fault_latched;
    logic          fault_clear_ack;
    logic [2:0]    state_out;

    int total = 0;
    int bad   = 0;

    rf_shutdown_sequencer #(
        .GAIN_W   (GW),
        .STEP     (STP),
        .RAMP_DIV (DIV)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .enable          (enable),
        .wd_warning      (wd_warning),
        .wd_triggered    (wd_triggered),
        .fault_clear     (fault_clear),
        .target_gain     (target_gain),
        .gain_out        (gain_out),
        .rf_enable       (rf_enable),
        .fault_latched   (fault_latched),
        .fault_clear_ack (fault_clear_ack),
        .state_out       (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_gain, m_age;
    bit m_rf, m_fault, m_ack;

    task automatic model_reset();
        m_state = S_MUTED; m_gain = 0; m_age = 0;
        m_rf = 0; m_fault = 0; m_ack = 0;
    endtask

    task automatic model_step();
        int eff, ns, g;
        bit rf, f, a, stepnow;
        eff = int'(target_gain);
`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
        if (wd_warning) eff = eff / 2;
`endif
        ns = m_state; g = m_gain; rf = m_rf; f = m_fault; a = 0;
        // A step lands on every DIV-th edge counted from the entry edge.
        stepnow = ((m_age + 1) % DIV) == 0;
        case (m_state)
            S_MUTED: begin
                g = 0; rf = 0;
                if (enable && !wd_triggered) begin ns = S_UP; rf = 1; end
            end
            S_UP: begin
                if (wd_triggered)      begin ns = S_DOWN; f = 1; end
                else if (!enable)      ns = S_DOWN;
                else if (m_gain >= eff) begin g = eff; ns = S_RUN; end
                else if (stepnow)      g = (m_gain + STP > eff) ? eff : m_gain + STP;
            end
            S_RUN: begin
                g = eff;
                if (wd_triggered) begin ns = S_DOWN; f = 1; end
                else if (!enable) ns = S_DOWN;
            end
            S_DOWN: begin
                if (wd_triggered) f = 1;
                if (m_gain == 0) begin ns = f ? S_FAULT : S_MUTED; rf = 0; end
                else if (stepnow) g = (m_gain - STP < 0) ? 0 : m_gain - STP;
            end
            default: begin
                g = 0; rf = 0;
                if (fault_clear && !wd_triggered) begin ns = S_MUTED; f = 0; a = 1; end
            end
        endcase
        m_age   = (ns == m_state) ? m_age + 1 : 0;
        m_state = ns; m_gain = g; m_rf = rf; m_fault = f; m_ack = a;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_reset();
        else       model_step();
    end

    // Single compare process: DUT vs model every cycle out of reset.
    always @(negedge clk) begin
        if (rstn) begin
            chk("m_gain",  32'(gain_out),        32'(m_gain));
            chk("m_rf",    32'(rf_enable),       32'(m_rf));
            chk("m_fault", 32'(fault_latched),   32'(m_fault));
            chk("m_ack",   32'(fault_clear_ack), 32'(m_ack));
            chk("m_state", 32'(state_out),       32'(m_state));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 0; enable = 0; wd_warning = 0; wd_triggered = 0;
        fault_clear = 0; target_gain = '0;
        cyc(3);
        chk("rst_gain",  32'(gain_out), 0);
        chk("rst_rf",    32'(rf_enable), 0);
        chk("rst_fault", 32'(fault_latched), 0);
        chk("rst_ack",   32'(fault_clear_ack), 0);
        chk("rst_state", 32'(state_out), S_MUTED);
        rstn = 1;
        cyc(2);

        // Ramp up to 64: 16,32,48,64 at 4-cycle spacing, then RUN.
        enable = 1; target_gain = 8'd64;
        cyc(1);
        chk("up_entry_state", 32'(state_out), S_UP);
        chk("up_entry_rf",    32'(rf_enable), 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(4);
            chk("up_gain", 32'(gain_out), 32'(16 * i));
        end
        cyc(1);
        chk("run_state", 32'(state_out), S_RUN);

        // Watchdog trip in RUN -> ramp down, fault latched, FAULT.
        wd_triggered = 1;
        cyc(1);
        chk("trip_state", 32'(state_out), S_DOWN);
        chk("trip_fault", 32'(fault_latched), 1);
        wd_triggered = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc(4);
            chk("down_gain", 32'(gain_out), 32'(64 - 16 * i));
        end
        chk("down_rf_still_on", 32'(rf_enable), 1);
        cyc(1);
        chk("fault_state", 32'(state_out), S_FAULT);
        chk("fault_rf",    32'(rf_enable), 0);

        // Clear while watchdog still high is ignored; then accepted.
        enable = 0; fault_clear = 1; wd_triggered = 1;
        cyc(1);
        chk("clr_blocked_state", 32'(state_out), S_FAULT);
        chk("clr_blocked_ack",   32'(fault_clear_ack), 0);
        wd_triggered = 0;
        cyc(1);
        chk("clr_state", 32'(state_out), S_MUTED);
        chk("clr_ack",   32'(fault_clear_ack), 1);
        chk("clr_fault", 32'(fault_latched), 0);
        fault_clear = 0;
        cyc(1);
        chk("ack_one_cycle", 32'(fault_clear_ack), 0);

        // Operator disable from RUN -> MUTED with no fault.
        enable = 1;
        cyc(18);
        chk("run2_gain", 32'(gain_out), 64);
        enable = 0;
        cyc(17);
        chk("dis_gain0", 32'(gain_out), 0);
        cyc(1);
        chk("dis_state", 32'(state_out), S_MUTED);
        chk("dis_fault", 32'(fault_latched), 0);

        // Target 250: last step saturates at 250 instead of wrapping through 256.
        target_gain = 8'd250; enable = 1;
        cyc(61);
        chk("sat_gain240", 32'(gain_out), 240);
        cyc(4);
        chk("sat_gain250", 32'(gain_out), 250);
        cyc(1);
        chk("sat_run", 32'(state_out), S_RUN);
`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
        wd_warning = 1;
        cyc(1);
        chk("warn_atten", 32'(gain_out), 125);
        wd_warning = 0;
        cyc(1);
        chk("warn_restore", 32'(gain_out), 250);
`endif
        // Ramp down 250: 10 after 15 steps, then clamps to 0 without wrapping.
        enable = 0;
        cyc(61);
        chk("dn_gain10", 32'(gain_out), 10);
        cyc(4);
        chk("dn_gain0", 32'(gain_out), 0);
        cyc(1);
        chk("dn_muted", 32'(state_out), S_MUTED);

        // Async reset mid-ramp zeroes everything at once.
        enable = 1;
        cyc(21);
        chk("mid_gain80", 32'(gain_out), 80);
        @(posedge clk);
        #2 rstn = 0;
        #1;
        chk("arst_gain",  32'(gain_out), 0);
        chk("arst_rf",    32'(rf_enable), 0);
        chk("arst_state", 32'(state_out), S_MUTED);
        chk("arst_fault", 32'(fault_latched), 0);
        @(negedge clk);
        rstn = 1;

        // Randomized traffic checked against the model by the compare process.
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            wd_triggered = ($urandom_range(0, 69) == 0);
            fault_clear  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) wd_warning = ~wd_warning;
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0:       target_gain = 8'd0;
                    1:       target_gain = 8'd250;
                    2:       target_gain = 8'd255;
                    3:       target_gain = 8'd64;
                    default: target_gain = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rstn = 0;
                #1 rstn = 1;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
